// File: rtl/peripheral_adder_pkg.sv
// Shared constants and helpers for the pipelined peripheral adder.
// The stage record is {valid, data[WIDTH:0], ovf}; each module declares it at its own WIDTH.
package peripheral_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned MAX_WIDTH = 64;

  // Packed width of one stage record: valid + (WIDTH+1) data bits + ovf.
  function automatic int unsigned stage_bits(int unsigned width);
    return width + 3;
  endfunction

  // Signed saturation limit: 0111..1 when neg=0, 1000..0 when neg=1.
  function automatic logic [MAX_WIDTH-1:0] sat_limit(int unsigned width, logic neg);
    logic [MAX_WIDTH-1:0] lim;
    lim = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width - 1) begin
        lim[i] = ~neg;
      end else if (i == width - 1) begin
        lim[i] = neg;
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/peripheral_adder_stage.sv
// One pipeline register slice holding a stage record {valid, data, ovf}.
module peripheral_adder_stage
  import peripheral_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [stage_bits(WIDTH)-1:0] d,
  output logic [stage_bits(WIDTH)-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/peripheral_adder_pipe.sv
// Pipelined add/subtract unit with carry/borrow, signed overflow and optional saturation.
// Arithmetic happens before stage 0; the whole pipe stalls together on output backpressure.
module peripheral_adder_pipe
  import peripheral_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             ovf,
  output logic             busy
);

  typedef struct packed {
    logic           valid;
    logic [WIDTH:0] data;
    logic           ovf;
  } stage_t;

  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_limit(WIDTH, 1'b0));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_limit(WIDTH, 1'b1));

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] raw;
  logic [WIDTH:0] res_next;
  logic           ovf_next;
  logic           en;

  // chain[0] is the freshly computed beat; chain[k] is the output of register stage k-1.
  stage_t chain [STAGES+1];

  assign sum  = {1'b0, ip1} + {1'b0, ip2};
  // Zero-extended subtraction leaves the borrow (ip1 < ip2) in the top bit.
  assign diff = {1'b0, ip1} - {1'b0, ip2};

  always_comb begin
    raw      = sum;
    ovf_next = 1'b0;
    case (op)
      OP_ADD: begin
        raw      = sum;
        ovf_next = (ip1[WIDTH-1] == ip2[WIDTH-1]) && (sum[WIDTH-1] != ip1[WIDTH-1]);
      end
      OP_SUB: begin
        raw      = diff;
        ovf_next = (ip1[WIDTH-1] != ip2[WIDTH-1]) && (diff[WIDTH-1] != ip1[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // Saturation clamps only the low bits; the carry/borrow bit stays raw.
  always_comb begin
    res_next = raw;
    if (SAT_EN && ovf_next) begin
      res_next[WIDTH-1:0] = ip1[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

  assign chain[0] = '{valid: in_valid, data: res_next, ovf: ovf_next};

  assign en       = !chain[STAGES].valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    peripheral_adder_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .en (en),
      .d  (chain[k]),
      .q  (chain[k+1])
    );
  end

  assign out_valid = chain[STAGES].valid;
  assign out       = chain[STAGES].data;
  assign ovf       = chain[STAGES].ovf;

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 1; k <= STAGES; k++) begin
      busy = busy | chain[k].valid;
    end
  end

endmodule

// File: tb/tb_peripheral_adder_pipe.sv
// Bench for peripheral_adder_pipe: three configurations driven from one source, checked
// against an integer-arithmetic model and a per-configuration result queue.
module tb_peripheral_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  always #5 clk = ~clk;

  logic [8:0]  o_a, o_s;
  logic [16:0] o_w;
  logic        ir_a, ir_s, ir_w, ovl_a, ovl_s, ovl_w, ov_a, ov_s, ov_w, bz_a, bz_s, bz_w;

  // 0: WIDTH=8 STAGES=2 wrap, 1: WIDTH=8 STAGES=2 saturate, 2: WIDTH=16 STAGES=4 wrap
  peripheral_adder_pipe #(.WIDTH(8), .STAGES(2), .SAT_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .op(op),
    .ip1(a[7:0]), .ip2(b[7:0]), .out_valid(ovl_a), .out_ready(out_ready),
    .out(o_a), .ovf(ov_a), .busy(bz_a)
  );
  peripheral_adder_pipe #(.WIDTH(8), .STAGES(2), .SAT_EN(1'b1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .op(op),
    .ip1(a[7:0]), .ip2(b[7:0]), .out_valid(ovl_s), .out_ready(out_ready),
    .out(o_s), .ovf(ov_s), .busy(bz_s)
  );
  peripheral_adder_pipe #(.WIDTH(16), .STAGES(4), .SAT_EN(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w), .op(op),
    .ip1(a), .ip2(b), .out_valid(ovl_w), .out_ready(out_ready),
    .out(o_w), .ovf(ov_w), .busy(bz_w)
  );

  logic [16:0] o   [3];
  logic        ov  [3];
  logic        ovl [3];
  logic        ir  [3];
  logic        bz  [3];

  assign o[0] = {8'h00, o_a};
  assign o[1] = {8'h00, o_s};
  assign o[2] = o_w;
  assign ov[0] = ov_a;  assign ov[1] = ov_s;  assign ov[2] = ov_w;
  assign ovl[0] = ovl_a; assign ovl[1] = ovl_s; assign ovl[2] = ovl_w;
  assign ir[0] = ir_a;  assign ir[1] = ir_s;  assign ir[2] = ir_w;
  assign bz[0] = bz_a;  assign bz[1] = bz_s;  assign bz[2] = bz_w;

  int tests = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Returns {ovf, out[16:0]} computed with plain signed/unsigned integer arithmetic.
  function automatic logic [17:0] model(input int w, input bit sat, input logic o_op,
                                        input longint x, input longint y);
    longint m, half, sa, sb, sr, raw;
    logic c, v;
    logic [17:0] r;
    m    = longint'(1) << w;
    half = m / 2;
    x    = x % m;
    y    = y % m;
    sa   = (x >= half) ? x - m : x;
    sb   = (y >= half) ? y - m : y;
    if (o_op == 1'b0) begin
      raw = x + y;
      c   = raw >= m;
      sr  = sa + sb;
    end else begin
      raw = x - y;
      c   = x < y;
      sr  = sa - sb;
    end
    raw = ((raw % m) + m) % m;
    v   = (sr > half - 1) || (sr < -half);
    if (sat && v) raw = (sa >= 0) ? half - 1 : half;
    r     = 18'(raw + (c ? m : longint'(0)));
    r[17] = v;
    return r;
  endfunction

  function automatic int cfg_w(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  logic [17:0] exp_mem [3][64];
  int          wr [3];
  int          rd [3];
  int          deliv [3];
  logic        pst [3];
  logic [18:0] prev [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0; rd[i] = 0; deliv[i] = 0; pst[i] = 1'b0; prev[i] = '0;
    end
  end

  // Checker: samples on the falling edge; inputs change just after the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!rst) begin
          chk("reset_out_valid", 32'(ovl[i]), 32'd0);
          chk("reset_busy", 32'(bz[i]), 32'd0);
          chk("reset_in_ready", 32'(ir[i]), 32'd1);
          chk("reset_out", 32'(o[i]), 32'd0);
          chk("reset_ovf", 32'(ov[i]), 32'd0);
          wr[i] = 0; rd[i] = 0; pst[i] = 1'b0;
        end else begin
          chk("in_ready", 32'(ir[i]), 32'(!ovl[i] || out_ready));
          chk("busy", 32'(bz[i]), 32'(wr[i] != rd[i]));
          if (ovl[i] && (wr[i] == rd[i])) chk("spurious_out_valid", 32'(ovl[i]), 32'd0);
          if (pst[i]) chk("stall_hold", 32'({ovl[i], ov[i], o[i]}), 32'(prev[i]));
          if (ovl[i] && out_ready && (wr[i] != rd[i])) begin
            chk($sformatf("result_dut%0d", i), 32'({ov[i], o[i]}), 32'(exp_mem[i][rd[i] % 64]));
            rd[i]++;
            deliv[i]++;
          end
          if (in_valid && ir[i]) begin
            exp_mem[i][wr[i] % 64] = model(cfg_w(i), (i == 1), op, longint'(a), longint'(b));
            wr[i]++;
          end
          pst[i]  = ovl[i] && !out_ready;
          prev[i] = {ovl[i], ov[i], o[i]};
        end
      end
    end
  end

  // Single beat into an empty pipe; checks latency and hand-computed results per config.
  task automatic directed(input string nm, input logic o_op, input logic [15:0] x, y,
                          input logic [9:0] ea, input logic [9:0] es, input logic [17:0] ew);
    int          lat [3];
    logic [17:0] got [3];
    for (int i = 0; i < 3; i++) begin lat[i] = -1; got[i] = '0; end
    @(posedge clk); #1;
    op = o_op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ovl[i] && lat[i] < 0) begin lat[i] = k; got[i] = {ov[i], o[i]}; end
      end
    end
    chk({nm, "_lat8"}, 32'(lat[0]), 32'd2);
    chk({nm, "_lat8sat"}, 32'(lat[1]), 32'd2);
    chk({nm, "_lat16"}, 32'(lat[2]), 32'd4);
    chk({nm, "_w8"}, 32'(got[0]), 32'({ea[9], 8'h00, ea[8:0]}));
    chk({nm, "_w8sat"}, 32'(got[1]), 32'({es[9], 8'h00, es[8:0]}));
    chk({nm, "_w16"}, 32'(got[2]), 32'(ew));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Expected values as {ovf, out}.
    directed("add_ff_01", 1'b0, 16'h00FF, 16'h0001, {1'b0, 9'h100}, {1'b0, 9'h100},
             {1'b0, 17'h00100});
    directed("add_7f_01", 1'b0, 16'h007F, 16'h0001, {1'b1, 9'h080}, {1'b1, 9'h07F},
             {1'b0, 17'h00080});
    directed("sub_05_07", 1'b1, 16'h0005, 16'h0007, {1'b0, 9'h1FE}, {1'b0, 9'h1FE},
             {1'b0, 17'h1FFFE});
    directed("sub_80_01", 1'b1, 16'h0080, 16'h0001, {1'b1, 9'h07F}, {1'b1, 9'h080},
             {1'b0, 17'h0007F});
    directed("add_80_80", 1'b0, 16'h0080, 16'h0080, {1'b1, 9'h100}, {1'b1, 9'h180},
             {1'b0, 17'h00100});
    directed("add_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, {1'b0, 9'h1FE}, {1'b0, 9'h1FE},
             {1'b0, 17'h1FFFE});

    // Back-to-back beats: the 16-bit, 4-stage pipe must deliver one result per cycle.
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      op = 1'b0; a = 16'(j * 16'h1111); b = 16'h0001; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("throughput_w16", 32'(ovl[2]), 32'd1);
    end
    repeat (6) @(posedge clk);

    // Backpressure: six beats with a four-cycle consumer stall in the middle.
    d0 = deliv[0];
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic rdy;
          int   n;
          op = i[0]; a = 16'(16'h0030 * i + 16'h0047); b = 16'(16'h0021 * i + 16'h0005);
          in_valid = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            rdy = ir[0];
            @(posedge clk); #1;
            n++;
          end while (!rdy && n < 50);
          if (!rdy) chk("bp_accept_timeout", 32'(rdy), 32'd1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", 32'(ir[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    chk("bp_delivered", 32'(deliv[0] - d0), 32'd6);

    // Reset mid-stream: three beats in flight, then an asynchronous reset pulse.
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      op = 1'b0; a = 16'(16'h0010 + j); b = 16'h0003; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_now_out_valid", 32'(ovl[0]), 32'd0);
    chk("rst_now_busy", 32'(bz[0]), 32'd0);
    chk("rst_now_in_ready", 32'(ir[0]), 32'd1);
    chk("rst_now_busy_w16", 32'(bz[2]), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'({ovl[0], ovl[1], ovl[2], bz[0], bz[1], bz[2]}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
